// File: rtl/rsc_pkg.sv
// Shared constants, types and the one-step trellis function of the LTE RSC encoder.
package rsc_pkg;

    localparam int unsigned NSTATE_BITS = 3;
    localparam int unsigned NTAIL       = 3;
    localparam int unsigned K_MIN       = 40;
    localparam int unsigned K_MAX       = 6144;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } fsm_t;

    // Result of one trellis step: feedback bit, parity bit, next state {s1,s2,s3}
    typedef struct packed {
        logic                   a;
        logic                   z;
        logic [NSTATE_BITS-1:0] s_next;
    } step_t;

    // One output pair plus its framing flags
    typedef struct packed {
        logic sys;
        logic par;
        logic tail;
        logic last;
    } out_beat_t;

    // s is packed {s1,s2,s3}: s[2]=s1, s[1]=s2, s[0]=s3
    function automatic step_t rsc_step(input logic u, input logic [NSTATE_BITS-1:0] s);
        step_t r;
        r.a      = u ^ s[1] ^ s[0];
        r.z      = r.a ^ s[2] ^ s[0];
        r.s_next = {r.a, s[2], s[1]};
        return r;
    endfunction

endpackage

// File: rtl/rsc_out_reg.sv
// One-deep valid/ready output register holding a systematic/parity pair and framing flags.
module rsc_out_reg (
    input  logic Clock,
    input  logic nReset,
    input  logic load_i,
    input  logic sys_i,
    input  logic par_i,
    input  logic tail_i,
    input  logic last_i,
    input  logic ready_i,
    output logic valid_o,
    output logic sys_o,
    output logic par_o,
    output logic tail_o,
    output logic last_o,
    output logic slot_free_c_o
);
    import rsc_pkg::*;

    logic      valid_q, valid_d;
    out_beat_t beat_q, beat_d;

    assign slot_free_c_o = !valid_q || ready_i;

    // A load overrides a drain so back-to-back pairs stream at one per cycle
    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (load_i) begin
            valid_d     = 1'b1;
            beat_d.sys  = sys_i;
            beat_d.par  = par_i;
            beat_d.tail = tail_i;
            beat_d.last = last_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign valid_o = valid_q;
    assign sys_o   = beat_q.sys;
    assign par_o   = beat_q.par;
    assign tail_o  = beat_q.tail;
    assign last_o  = beat_q.last;

endmodule

// File: rtl/rsc_term_encoder.sv
// Streaming LTE constituent RSC encoder, one bit per cycle, with 3-cycle trellis termination.
// Define FRAME_LEN_CHECK_EN to add the frame length counter that drives len_err.
module rsc_term_encoder #(
    parameter int unsigned K     = 6144,
    parameter int unsigned NTAIL = 3
) (
    input  logic Clock,
    input  logic nReset,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic out_sys,
    output logic out_par,
    output logic out_tail,
    output logic out_last,
    output logic busy,
    output logic len_err
);
    import rsc_pkg::*;

    localparam int unsigned TCNT_W = $clog2(NTAIL + 1);

    if (K < K_MIN || K > K_MAX) begin : g_k_range
        $error("rsc_term_encoder: K outside the LTE range");
    end

    fsm_t                   state_q, state_d;
    logic [NSTATE_BITS-1:0] trellis_q, trellis_d;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic                   busy_q, busy_d;

    logic      slot_free;
    logic      accept;
    logic      load;
    logic      force_tail;
    logic      tail_u;
    logic      tail_final;
    step_t     data_step;
    step_t     tail_step;
    out_beat_t ld_beat;
    logic      unused_fb;

    assign in_ready   = slot_free && (state_q != TAIL);
    assign accept     = in_valid && in_ready;
    assign data_step  = rsc_step(in_bit, trellis_q);
    // Tail input cancels the feedback so the register shifts in zeros
    assign tail_u     = trellis_q[1] ^ trellis_q[0];
    assign tail_step  = rsc_step(tail_u, trellis_q);
    assign tail_final = (tcnt_q == TCNT_W'(NTAIL - 1));
    assign unused_fb  = data_step.a ^ tail_step.a;

`ifdef FRAME_LEN_CHECK_EN
    localparam int unsigned      CNT_W   = $clog2(K + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(K);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(K_MIN);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             len_err_q, len_err_d;

    // Counts accepted data bits; overlong frames are cut off into the tail
    always_comb begin
        cnt_d      = cnt_q;
        len_err_d  = len_err_q;
        force_tail = 1'b0;
        if (accept) begin
            if (state_q == IDLE) begin
                cnt_d     = CNT_W'(1);
                len_err_d = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
                if (!in_last) begin
                    force_tail = 1'b1;
                    len_err_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (in_last && (cnt_d < CNT_MIN)) begin
                len_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign force_tail = 1'b0;
    assign len_err    = 1'b0;
`endif

    // Next-state, trellis update and output-register load
    always_comb begin
        state_d   = state_q;
        trellis_d = trellis_q;
        tcnt_d    = tcnt_q;
        busy_d    = busy_q;
        load      = 1'b0;
        ld_beat   = '0;

        if (out_valid && out_ready && out_last) begin
            busy_d = 1'b0;
        end

        case (state_q)
            IDLE, DATA: begin
                if (accept) begin
                    load         = 1'b1;
                    ld_beat.sys  = in_bit;
                    ld_beat.par  = data_step.z;
                    trellis_d    = data_step.s_next;
                    busy_d       = 1'b1;
                    state_d      = (in_last || force_tail) ? TAIL : DATA;
                end
            end
            TAIL: begin
                if (slot_free) begin
                    load         = 1'b1;
                    ld_beat.sys  = tail_u;
                    ld_beat.par  = tail_step.z;
                    ld_beat.tail = 1'b1;
                    ld_beat.last = tail_final;
                    trellis_d    = tail_step.s_next;
                    if (tail_final) begin
                        tcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q   <= IDLE;
            trellis_q <= '0;
            tcnt_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            trellis_q <= trellis_d;
            tcnt_q    <= tcnt_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;

    rsc_out_reg u_out_reg (
        .Clock         (Clock),
        .nReset        (nReset),
        .load_i        (load),
        .sys_i         (ld_beat.sys),
        .par_i         (ld_beat.par),
        .tail_i        (ld_beat.tail),
        .last_i        (ld_beat.last),
        .ready_i       (out_ready),
        .valid_o       (out_valid),
        .sys_o         (out_sys),
        .par_o         (out_par),
        .tail_o        (out_tail),
        .last_o        (out_last),
        .slot_free_c_o (slot_free)
    );

endmodule

// File: tb/tb_rsc_term_encoder.sv
// Self-checking bench for rsc_term_encoder: fixed vectors, handshake corner cases and
// random frames against a feedback-sequence model of the LTE RSC code.
module tb_rsc_term_encoder;

`ifdef FRAME_LEN_CHECK_EN
    localparam int unsigned TB_K = 40;
`else
    localparam int unsigned TB_K = 6144;
`endif

    logic Clock     = 1'b0;
    logic nReset    = 1'b0;
    logic in_valid  = 1'b0;
    logic in_bit    = 1'b0;
    logic in_last   = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, len_err;

    always #5 Clock = ~Clock;

    rsc_term_encoder #(.K(TB_K), .NTAIL(3)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sys   (out_sys),
        .out_par   (out_par),
        .out_tail  (out_tail),
        .out_last  (out_last),
        .busy      (busy),
        .len_err   (len_err)
    );

    typedef struct packed {
        logic sys;
        logic par;
        logic tail;
        logic last;
    } beat_t;

    typedef struct {
        bit    u;
        beat_t exp;
    } vec_t;

    vec_t  tbl[7];
    beat_t obs_q[$];
    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    rdy_mode = 0;
    int    cyc = 0;
    bit    acc_now = 1'b0;
    bit    stall_prev = 1'b0;
    beat_t held_beat = '0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected pairs from the code recurrence: a[n] = u[n]^a[n-2]^a[n-3], z[n] = a[n]^a[n-1]^a[n-3]
    function automatic void expect_frame(input bit bits[$], input bit add_tail);
        bit ah[$] = '{1'b0, 1'b0, 1'b0};
        bit a, z, u;
        for (int i = 0; i < bits.size(); i++) begin
            a = bits[i] ^ ah[1] ^ ah[2];
            z = a ^ ah[0] ^ ah[2];
            exp_q.push_back({bits[i], z, 1'b0, 1'b0});
            ah.push_front(a);
            void'(ah.pop_back());
        end
        if (add_tail) begin
            for (int t = 0; t < 3; t++) begin
                u = ah[1] ^ ah[2];
                z = ah[0] ^ ah[2];
                exp_q.push_back({u, z, 1'b1, (t == 2) ? 1'b1 : 1'b0});
                ah.push_front(1'b0);
                void'(ah.pop_back());
            end
        end
    endfunction

    // One clock: set out_ready, sample #1 into the cycle, then wait for the next falling edge
    task automatic tick();
        beat_t cur;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        cyc++;
        #1;
        cur = {out_sys, out_par, out_tail, out_last};
        if (stall_prev && nReset) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_pair", int'(cur), int'(held_beat));
        end
        stall_prev = out_valid && !out_ready;
        held_beat  = cur;
        if (stall_prev) check("in_ready_while_full", int'(in_ready), 0);
        if (out_valid && out_ready) obs_q.push_back(cur);
        acc_now = in_valid && in_ready;
        @(negedge Clock);
    endtask

    task automatic send_frame(input bit bits[$], input bit with_last, input int gap_max,
                              output int first_wait);
        int waits;
        first_wait = 0;
        for (int i = 0; i < bits.size(); i++) begin
            if (gap_max > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) tick();
            end
            in_valid = 1'b1;
            in_bit   = bits[i];
            in_last  = with_last && (i == bits.size() - 1);
            waits    = 0;
            tick();
            while (!acc_now && waits < 200) begin
                waits++;
                tick();
            end
            if (!acc_now) begin
                n_chk++;
                n_fail++;
                $display("FAIL accept_timeout: bit %0d not accepted after %0d cycles", i, waits);
                break;
            end
            if (i == 0) first_wait = waits;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_and_compare(input string name);
        int budget = 0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (obs_q.size() < exp_q.size() && budget < 1000) begin
            tick();
            budget++;
        end
        repeat (2) tick();
        check({name, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({name, "_pair"}, int'(obs_q[i]), int'(exp_q[i]));
        check({name, "_busy_end"}, int'(busy), 0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_table(input string name);
        bit bits[$];
        int w;
        for (int i = 0; i < 7; i++) begin
            if (!tbl[i].exp.tail) bits.push_back(tbl[i].u);
            exp_q.push_back(tbl[i].exp);
        end
        send_frame(bits, 1'b1, 0, w);
        drain_and_compare(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bits[$];
        bit rb[$];
        int w;
        int n;

        // Frame 1,0,0,1 followed by its three termination pairs
        tbl[0] = '{1'b1, 4'b1100};
        tbl[1] = '{1'b0, 4'b0100};
        tbl[2] = '{1'b0, 4'b0100};
        tbl[3] = '{1'b1, 4'b1000};
        tbl[4] = '{1'b0, 4'b1010};
        tbl[5] = '{1'b0, 4'b1110};
        tbl[6] = '{1'b0, 4'b0011};

        nReset = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_len_err", int'(len_err), 0);
        check("rst_pair", int'({out_sys, out_par, out_tail, out_last}), 0);
        nReset = 1'b1;
        @(negedge Clock);
        check("idle_in_ready", int'(in_ready), 1);

        rdy_mode = 0;
        run_table("frame1001");
`ifdef FRAME_LEN_CHECK_EN
        check("short_frame_len_err", int'(len_err), 1);
`else
        check("len_err_tied", int'(len_err), 0);
`endif

        rdy_mode = 1;
        cyc = 0;
        run_table("frame1001_bp");

        // 1-bit frame, then 1,0,0,1 with in_valid held through the tail
        rdy_mode = 0;
        bits = '{1'b1};
        expect_frame(bits, 1'b1);
        send_frame(bits, 1'b1, 0, w);
        bits = '{1'b1, 1'b0, 1'b0, 1'b1};
        expect_frame(bits, 1'b1);
        send_frame(bits, 1'b1, 0, w);
        check("tail_in_ready_low_cycles", w, 3);
        drain_and_compare("onebit_b2b");

        // Reset after the second bit discards the frame
        bits = '{1'b1, 1'b0};
        send_frame(bits, 1'b0, 0, w);
        nReset = 1'b0;
        tick();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_len_err", int'(len_err), 0);
        nReset = 1'b1;
        obs_q.delete();
        exp_q.delete();
        stall_prev = 1'b0;
        run_table("after_reset");

        rdy_mode = 2;
        for (int f = 0; f < 25; f++) begin
            rb.delete();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) rb.push_back(1'($urandom_range(0, 1)));
            expect_frame(rb, 1'b1);
            send_frame(rb, 1'b1, 2, w);
        end
        drain_and_compare("random");

        rdy_mode = 0;
        bits.delete();
`ifdef FRAME_LEN_CHECK_EN
        for (int i = 0; i < 41; i++) bits.push_back(1'($urandom_range(0, 1)));
        send_frame(bits[0:0], 1'b0, 0, w);
        check("len_err_clear_on_start", int'(len_err), 0);
        send_frame(bits[1:$], 1'b0, 0, w);
        check("len_err_overflow", int'(len_err), 1);
        expect_frame(bits, 1'b1);
        drain_and_compare("overflow_forced_tail");
        bits.delete();
        for (int i = 0; i < 40; i++) bits.push_back(1'($urandom_range(0, 1)));
        expect_frame(bits, 1'b1);
        send_frame(bits[0:0], 1'b0, 0, w);
        check("len_err_clear_next", int'(len_err), 0);
        send_frame(bits[1:$], 1'b1, 0, w);
        check("len_err_min_len_ok", int'(len_err), 0);
        drain_and_compare("min_len_frame");
`else
        for (int i = 0; i < 45; i++) bits.push_back(1'($urandom_range(0, 1)));
        send_frame(bits[0:43], 1'b0, 0, w);
        check("long_no_tail_in_ready", int'(in_ready), 1);
        send_frame(bits[44:44], 1'b1, 0, w);
        expect_frame(bits, 1'b1);
        drain_and_compare("long_frame");
        check("len_err_tied_end", int'(len_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
